csr_unit: RTL and testbench
===========================

// Module: csr_unit
// PURPOSE
//  Machine-mode CSR unit for the core: CSR read/modify/write, 64-bit cycle and
//  instret counters with multi-instruction retire, trap entry, MRET return and
//  external-interrupt gating. Sits beside the control unit; supplies the trap
//  handler PC and the interrupt request to the fetch/redirect logic.
// PARAMETERS
//  RETIRE_WIDTH  2             max instructions retired per cycle (1..4)
//  MTVEC_RESET   32'h0000_0000 reset value of mtvec
//  MISA_VALUE    32'h4000_0100 constant misa contents (RV32I)
// PORTS
//  clock          in   1    clock
//  reset          in   1    synchronous, active-high reset
//  csr_valid      in   1    CSR instruction accesses csr_addr this cycle
//  csr_op         in   2    01 write, 10 set (|=), 11 clear (&=~); 00 read-only
//  csr_addr       in   12   CSR address
//  csr_wdata      in   32   write data / bit mask
//  csr_rdata      out  32   current value at csr_addr (combinational)
//  csr_illegal    out  1    csr_valid with unknown address or write to RO CSR
//  retire_count   in   $clog2(RETIRE_WIDTH+1)  instructions retired this cycle
//  trap_valid     in   1    take a trap this cycle
//  trap_cause     in   32   mcause value (bit 31 = interrupt)
//  trap_pc        in   32   PC of trapping instruction
//  trap_tval      in   32   mtval value
//  mret_valid     in   1    MRET executes this cycle
//  irq_external   in   1    level-sensitive external interrupt line
//  trap_vector    out  32   handler PC for trap_cause (combinational)
//  mepc_out       out  32   current mepc (MRET target)
//  irq_pending    out  1    mstatus.MIE & mie.MEIE & irq_external
// BEHAVIOUR
//  - Map: mstatus 300, misa 301 (RO, writes ignored not illegal), mie 304, mtvec 305,
//    mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (RO, bit11=irq_external),
//    mcycle B00, minstret B02, mcycleh B80, minstreth B82, cycle/instret(h)
//    C00/C02/C80/C82 RO. Any other address -> csr_illegal.
//  - csr_illegal when csr_valid & (unmapped | (op!=00 & addr[11:10]==2'b11)
//    except misa/mip writes are ignored silently). Illegal access: no state change.
//  - Write lands at clock edge; new = op01 wdata, op10 old|wdata, op11 old&~wdata.
//  - mstatus: only MIE(3), MPIE(7) writable; MPP[12:11] hardwired 2'b11.
//    mepc[1:0] forced 0; mtvec[1] forced 0; mie only bits 3,7,11 writable.
//  - mcycle: 64-bit, +1 every cycle. Write to mcycle/mcycleh replaces that half;
//    that cycle the whole counter does not increment. Wraps 2^64-1 -> 0.
//  - minstret: 64-bit, += retire_count each cycle; same write-suppress rule.
//  - Trap (edge with trap_valid): mepc<=trap_pc&~3, mcause<=trap_cause,
//    mtval<=trap_tval, MPIE<=MIE, MIE<=0. Counters still count.
//  - MRET (edge with mret_valid, no trap): MIE<=MPIE, MPIE<=1.
//  - Priority same cycle: trap > mret > CSR write; lower ones are dropped whole.
//  - trap_vector: mtvec mode 0 -> {base,2'b00}; mode 1 & trap_cause[31] ->
//    base + 4*trap_cause[4:0]; mode 1 exception -> base.
//  - Reset: all CSRs 0 except mtvec=MTVEC_RESET, mstatus=32'h0000_1800;
//    outputs follow: csr_rdata per addr, csr_illegal 0 if !csr_valid,
//    irq_pending 0, mepc_out 0, trap_vector=MTVEC_RESET. Reset overrides all.
// TESTING
//  - Reset then read 301 -> 4000_0100; read 300 -> 0000_1800; read C00 after
//    5 cycles -> 5.
//  - csrrs 300 wdata 8 then csrrc 300 wdata 8 -> 0000_1808, then 0000_1800.
//  - Write mcycle=FFFF_FFFF, mcycleh=0 -> next cycles read mcycleh=1, mcycle=0..;
//    write cycle suppresses increment (read back FFFF_FFFF then 0000_0000).
//  - retire_count=2 for 10 cycles -> minstret 20; write C02 -> csr_illegal=1, no change.
//  - MIE=1, MEIE=1, irq_external=1 -> irq_pending=1; trap cause 8000_000B pc 0x103
//    with mtvec 0x201 -> trap_vector 0x22C, mepc 0x100, MIE=0 MPIE=1, irq_pending=0.
//  - trap_valid & mret_valid & csr write mscratch same cycle -> only trap effects;
//    MRET next cycle -> MIE=1, MPIE=1, mscratch unchanged.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR read/modify/write, 64-bit cycle/instret counters,
// trap entry, MRET return and external-interrupt gating.
module csr_unit #(
  parameter int          RETIRE_WIDTH = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE   = 32'h4000_0100
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              csr_valid,
  input  logic [1:0]                        csr_op,
  input  logic [11:0]                       csr_addr,
  input  logic [31:0]                       csr_wdata,
  output logic [31:0]                       csr_rdata,
  output logic                              csr_illegal,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_count,
  input  logic                              trap_valid,
  input  logic [31:0]                       trap_cause,
  input  logic [31:0]                       trap_pc,
  input  logic [31:0]                       trap_tval,
  input  logic                              mret_valid,
  input  logic                              irq_external,
  output logic [31:0]                       trap_vector,
  output logic [31:0]                       mepc_out,
  output logic                              irq_pending
);

  localparam int RCW = $clog2(RETIRE_WIDTH + 1);

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_reg;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic        mapped;
  logic [31:0] wnew;
  logic        wr_en;
  logic [31:0] tvec_base;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mip_val     = {20'b0, irq_external, 11'b0};

  always_comb begin
    csr_rdata = 32'h0;
    mapped    = 1'b1;
    case (csr_addr)
      12'h300:          csr_rdata = mstatus_val;
      12'h301:          csr_rdata = MISA_VALUE;
      12'h304:          csr_rdata = mie_reg;
      12'h305:          csr_rdata = mtvec;
      12'h340:          csr_rdata = mscratch;
      12'h341:          csr_rdata = mepc;
      12'h342:          csr_rdata = mcause;
      12'h343:          csr_rdata = mtval;
      12'h344:          csr_rdata = mip_val;
      12'hB00, 12'hC00: csr_rdata = mcycle[31:0];
      12'hB02, 12'hC02: csr_rdata = minstret[31:0];
      12'hB80, 12'hC80: csr_rdata = mcycle[63:32];
      12'hB82, 12'hC82: csr_rdata = minstret[63:32];
      default:          mapped = 1'b0;
    endcase
  end

  // The 0xC.. user-level counter aliases are the only read-only space that faults on write
  assign csr_illegal = csr_valid & (~mapped | ((csr_op != 2'b00) & (csr_addr[11:10] == 2'b11)));
  assign wr_en       = csr_valid & ~csr_illegal & (csr_op != 2'b00) & ~trap_valid & ~mret_valid;

  always_comb begin
    case (csr_op)
      2'b01:   wnew = csr_wdata;
      2'b10:   wnew = csr_rdata | csr_wdata;
      2'b11:   wnew = csr_rdata & ~csr_wdata;
      default: wnew = csr_rdata;
    endcase
  end

  assign tvec_base   = {mtvec[31:2], 2'b00};
  assign trap_vector = ((mtvec[1:0] == 2'b01) && trap_cause[31])
                       ? tvec_base + {25'b0, trap_cause[4:0], 2'b00} : tvec_base;
  assign mepc_out    = mepc;
  assign irq_pending = mstatus_mie & mie_reg[11] & irq_external;

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_reg      <= 32'h0;
      mtvec        <= MTVEC_RESET;
      mscratch     <= 32'h0;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
      mtval        <= 32'h0;
      mcycle       <= 64'h0;
      minstret     <= 64'h0;
    end else begin
      // A write to either half freezes the whole counter for that cycle
      if (wr_en && csr_addr == 12'hB00)      mcycle[31:0]  <= wnew;
      else if (wr_en && csr_addr == 12'hB80) mcycle[63:32] <= wnew;
      else                                   mcycle        <= mcycle + 64'd1;

      if (wr_en && csr_addr == 12'hB02)      minstret[31:0]  <= wnew;
      else if (wr_en && csr_addr == 12'hB82) minstret[63:32] <= wnew;
      else minstret <= minstret + {{(64-RCW){1'b0}}, retire_count};

      if (trap_valid) begin
        mepc         <= {trap_pc[31:2], 2'b00};
        mcause       <= trap_cause;
        mtval        <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_valid) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr)
          12'h300: begin
            mstatus_mie  <= wnew[3];
            mstatus_mpie <= wnew[7];
          end
          12'h304: mie_reg  <= wnew & 32'h0000_0888;
          12'h305: mtvec    <= {wnew[31:2], 1'b0, wnew[0]};
          12'h340: mscratch <= wnew;
          12'h341: mepc     <= {wnew[31:2], 2'b00};
          12'h342: mcause   <= wnew;
          12'h343: mtval    <= wnew;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: a table of single-cycle CSR accesses plus
// hand-written counter, trap and MRET sequences, checked through a scoreboard queue.
module tb_csr_unit;

  localparam logic [31:0] MTV_RST = 32'h0000_0080;
  localparam int SEL_RD = 0, SEL_ILL = 1, SEL_IRQ = 2, SEL_TVEC = 3, SEL_MEPC = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [1:0]  retire_count;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        irq_external;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        irq_pending;

  int checks = 0;
  int errors = 0;

  csr_unit #(.RETIRE_WIDTH(2), .MTVEC_RESET(MTV_RST), .MISA_VALUE(32'h4000_0100)) dut (
    .clock(clock), .reset(reset),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .retire_count(retire_count),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .irq_external(irq_external),
    .trap_vector(trap_vector), .mepc_out(mepc_out), .irq_pending(irq_pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] pick(input int s);
    case (s)
      SEL_RD:   return csr_rdata;
      SEL_ILL:  return {31'b0, csr_illegal};
      SEL_IRQ:  return {31'b0, irq_pending};
      SEL_TVEC: return trap_vector;
      default:  return mepc_out;
    endcase
  endfunction

  task automatic expect_val(input string nm, input int s, input logic [31:0] v);
    sb_t e;
    e.name = nm; e.sel = s; e.exp = v;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge, then advance past the rising edge
  task automatic cycle();
    sb_t e;
    logic [31:0] act;
    @(negedge clock);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual %h expected %h", e.name, act, e.exp);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0;
    trap_valid = 1'b0; mret_valid = 1'b0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
  endtask

  task automatic rd(input logic [11:0] addr);
    csr(2'b00, addr, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; csr_addr = 12'h000; retire_count = 2'd0; irq_external = 1'b0;
    trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
    idle();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    csr_addr = 12'hC00;
    expect_val("rst_cycle0", SEL_RD, 32'h0);
    expect_val("rst_illegal", SEL_ILL, 32'h0);
    expect_val("rst_irq", SEL_IRQ, 32'h0);
    expect_val("rst_mepc", SEL_MEPC, 32'h0);
    expect_val("rst_tvec", SEL_TVEC, MTV_RST);
    cycle();
    repeat (4) @(posedge clock);
    #1;
    expect_val("cycle_after5", SEL_RD, 32'd5);
    cycle();

    vq.push_back('{1'b1, 2'b00, 12'h301, 32'h0,        1'b1, 32'h4000_0100, 1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h300, 32'h0,        1'b1, 32'h0000_1800, 1'b0});
    vq.push_back('{1'b1, 2'b10, 12'h300, 32'h8,        1'b1, 32'h0000_1800, 1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h300, 32'h0,        1'b1, 32'h0000_1808, 1'b0});
    vq.push_back('{1'b1, 2'b11, 12'h300, 32'h8,        1'b1, 32'h0000_1808, 1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h300, 32'h0,        1'b1, 32'h0000_1800, 1'b0});
    vq.push_back('{1'b1, 2'b01, 12'h300, 32'hFFFF_FFFF, 1'b1, 32'h0000_1800, 1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h300, 32'h0,        1'b1, 32'h0000_1888, 1'b0});
    vq.push_back('{1'b1, 2'b01, 12'h300, 32'h0,        1'b1, 32'h0000_1888, 1'b0});
    vq.push_back('{1'b1, 2'b01, 12'h301, 32'h1234,     1'b1, 32'h4000_0100, 1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h301, 32'h0,        1'b1, 32'h4000_0100, 1'b0});
    vq.push_back('{1'b1, 2'b01, 12'h304, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h304, 32'h0,        1'b1, 32'h0000_0888, 1'b0});
    vq.push_back('{1'b1, 2'b01, 12'h341, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h341, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0});
    vq.push_back('{1'b1, 2'b01, 12'h305, 32'hFFFF_FFFF, 1'b1, MTV_RST,       1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h305, 32'h0,        1'b1, 32'hFFFF_FFFD, 1'b0});
    vq.push_back('{1'b1, 2'b01, 12'h340, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h340, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0});
    vq.push_back('{1'b1, 2'b11, 12'h340, 32'h0000_FFFF, 1'b1, 32'hDEAD_BEEF, 1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h340, 32'h0,        1'b1, 32'hDEAD_0000, 1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h7FF, 32'h0,        1'b1, 32'h0,         1'b1});
    vq.push_back('{1'b1, 2'b01, 12'hC00, 32'h0,        1'b0, 32'h0,         1'b1});
    vq.push_back('{1'b0, 2'b00, 12'h7FF, 32'h0,        1'b1, 32'h0,         1'b0});
    vq.push_back('{1'b1, 2'b01, 12'h344, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h342, 32'h0,        1'b1, 32'h0,         1'b0});
    vq.push_back('{1'b1, 2'b00, 12'h343, 32'h0,        1'b1, 32'h0,         1'b0});

    for (int i = 0; i < vq.size(); i++) begin
      csr_valid = vq[i].valid; csr_op = vq[i].op; csr_addr = vq[i].addr; csr_wdata = vq[i].wdata;
      if (vq[i].chk_rd) expect_val($sformatf("vec%0d_rdata", i), SEL_RD, vq[i].exp_rd);
      expect_val($sformatf("vec%0d_illegal", i), SEL_ILL, {31'b0, vq[i].exp_ill});
      cycle();
    end

    // mcycle low/high writes, suppressed increment, then 32-bit carry
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); cycle();
    csr(2'b01, 12'hB80, 32'h0);
    expect_val("mcycleh_before", SEL_RD, 32'h0); cycle();
    rd(12'hB00); expect_val("mcycle_suppr", SEL_RD, 32'hFFFF_FFFF); cycle();
    rd(12'hB00); expect_val("mcycle_wrap", SEL_RD, 32'h0); cycle();
    rd(12'hC80); expect_val("cycleh_carry", SEL_RD, 32'h1); cycle();
    rd(12'hC00); expect_val("cycle_after", SEL_RD, 32'h2); cycle();

    // minstret multi-retire accumulation
    csr(2'b01, 12'hB02, 32'h0); cycle();
    csr(2'b01, 12'hB82, 32'h0); cycle();
    idle(); retire_count = 2'd2;
    repeat (10) cycle();
    retire_count = 2'd0;
    rd(12'hB02); expect_val("minstret20", SEL_RD, 32'd20); cycle();
    csr(2'b01, 12'hC02, 32'h0); expect_val("instret_wr_ill", SEL_ILL, 32'h1); cycle();
    rd(12'hC02); expect_val("instret_nochg", SEL_RD, 32'd20);
    expect_val("instret_rd_ok", SEL_ILL, 32'h0); cycle();
    rd(12'hB82); expect_val("minstreth0", SEL_RD, 32'h0); cycle();
    retire_count = 2'd2; csr(2'b01, 12'hB02, 32'd5); cycle();
    retire_count = 2'd0;
    rd(12'hB02); expect_val("minstret_suppr", SEL_RD, 32'd5); cycle();

    // interrupt gating and trap entry
    csr(2'b10, 12'h300, 32'h8); cycle();
    irq_external = 1'b1;
    rd(12'h344); expect_val("mip_meip", SEL_RD, 32'h0000_0800);
    expect_val("irq_pending1", SEL_IRQ, 32'h1); cycle();
    csr(2'b01, 12'h305, 32'h0000_0201); cycle();
    idle();
    trap_valid = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_0103; trap_tval = 32'h55;
    expect_val("tvec_vectored", SEL_TVEC, 32'h0000_022C); cycle();
    trap_valid = 1'b0;
    rd(12'h300); expect_val("mstatus_trap", SEL_RD, 32'h0000_1880);
    expect_val("irq_masked", SEL_IRQ, 32'h0);
    expect_val("mepc_trap", SEL_MEPC, 32'h0000_0100); cycle();
    rd(12'h342); expect_val("mcause_trap", SEL_RD, 32'h8000_000B); cycle();
    rd(12'h343); expect_val("mtval_trap", SEL_RD, 32'h55); cycle();
    trap_cause = 32'h2;
    expect_val("tvec_exception", SEL_TVEC, 32'h0000_0200); cycle();

    // trap beats mret beats CSR write in the same cycle
    idle(); mret_valid = 1'b1; cycle();
    mret_valid = 1'b0;
    rd(12'h300); expect_val("mstatus_mret", SEL_RD, 32'h0000_1888); cycle();
    csr(2'b01, 12'h340, 32'h1234_5678);
    trap_valid = 1'b1; mret_valid = 1'b1; trap_pc = 32'h0000_0208; cycle();
    idle();
    rd(12'h300); expect_val("mstatus_prio", SEL_RD, 32'h0000_1880);
    expect_val("mepc_prio", SEL_MEPC, 32'h0000_0208); cycle();
    rd(12'h340); expect_val("mscratch_prio", SEL_RD, 32'hDEAD_0000); cycle();
    idle(); mret_valid = 1'b1; cycle();
    mret_valid = 1'b0;
    rd(12'h300); expect_val("mstatus_mret2", SEL_RD, 32'h0000_1888); cycle();
    rd(12'h340); expect_val("mscratch_kept", SEL_RD, 32'hDEAD_0000); cycle();

    // reset overrides everything
    idle(); reset = 1'b1; cycle();
    reset = 1'b0;
    rd(12'h340); expect_val("rst2_mscratch", SEL_RD, 32'h0);
    expect_val("rst2_mepc", SEL_MEPC, 32'h0);
    expect_val("rst2_tvec", SEL_TVEC, MTV_RST);
    expect_val("rst2_irq", SEL_IRQ, 32'h0); cycle();
    rd(12'h300); expect_val("rst2_mstatus", SEL_RD, 32'h0000_1800); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
